// File: rtl/fpu_cmd_sequencer.sv
// Command sequencer in front of FPU_Core: queues host commands, issues each with a one-cycle
// execute pulse, supervises the ready handshake and returns one response per command.
module fpu_cmd_sequencer #(
    parameter int DEPTH          = 4,
    parameter int START_WINDOW   = 100,
    parameter int TIMEOUT_CYCLES = 10000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [7:0]  cmd_inst,
    input  logic [2:0]  cmd_idx,
    input  logic [79:0] cmd_data,
    input  logic        cmd_mem,
    input  logic [1:0]  cmd_size,
    input  logic        cmd_int,
    input  logic        cmd_bcd,
    output logic [7:0]  fpu_instruction,
    output logic [2:0]  fpu_stack_index,
    output logic [79:0] fpu_data_in,
    output logic        fpu_has_memory_op,
    output logic [1:0]  fpu_operand_size,
    output logic        fpu_is_integer,
    output logic        fpu_is_bcd,
    output logic        fpu_execute,
    input  logic        fpu_ready,
    input  logic [79:0] fpu_data_out,
    input  logic [15:0] fpu_status,
    output logic        fpu_abort,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [79:0] rsp_data,
    output logic [15:0] rsp_status,
    output logic [1:0]  rsp_code,
    output logic [15:0] rsp_cycles,
    output logic        busy
);
    localparam int AW = $clog2(DEPTH);

    typedef enum logic [2:0] {IDLE, ISSUE, WAIT_START, WAIT_DONE, RESP} state_t;

    typedef struct packed {
        logic [7:0]  inst;
        logic [2:0]  idx;
        logic [79:0] data;
        logic        mem;
        logic [1:0]  size;
        logic        is_int;
        logic        bcd;
    } cmd_t;

    cmd_t          fifo_mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    state_t        state_q, state_d;
    logic [15:0]   cnt_q, cnt_d;
    cmd_t          op_q, op_d;
    logic          exec_q, exec_d, abort_q, abort_d;
    logic          rsp_valid_q, rsp_valid_d;
    logic [79:0]   rsp_data_q, rsp_data_d;
    logic [15:0]   rsp_status_q, rsp_status_d, rsp_cycles_q, rsp_cycles_d;
    logic [1:0]    rsp_code_q, rsp_code_d;
    logic          busy_q, busy_d, cmd_ready_q, cmd_ready_d;
    logic          push_s, pop_s;
    cmd_t          in_cmd_s;

    assign in_cmd_s = '{inst: cmd_inst, idx: cmd_idx, data: cmd_data, mem: cmd_mem,
                        size: cmd_size, is_int: cmd_int, bcd: cmd_bcd};
    assign push_s   = cmd_valid && cmd_ready_q;

    // Next-state, response capture and FIFO bookkeeping
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        op_d         = op_q;
        exec_d       = 1'b0;
        abort_d      = 1'b0;
        rsp_valid_d  = rsp_valid_q;
        rsp_data_d   = rsp_data_q;
        rsp_status_d = rsp_status_q;
        rsp_code_d   = rsp_code_q;
        rsp_cycles_d = rsp_cycles_q;
        pop_s        = 1'b0;
        case (state_q)
            IDLE: begin
                if ((count_q != '0) && fpu_ready) begin
                    op_d    = fifo_mem_q[rd_ptr_q];
                    pop_s   = 1'b1;
                    exec_d  = 1'b1;
                    state_d = ISSUE;
                end else begin
                    state_d = IDLE;
                end
            end
            ISSUE: begin
                cnt_d   = 16'd0;
                state_d = WAIT_START;
            end
            WAIT_START: begin
                if (!fpu_ready) begin
                    cnt_d   = 16'd0;
                    state_d = WAIT_DONE;
                end else if (cnt_q == 16'(START_WINDOW - 1)) begin
                    rsp_data_d   = 80'd0;
                    rsp_status_d = fpu_status;
                    rsp_cycles_d = 16'd0;
                    rsp_code_d   = 2'd1;
                    rsp_valid_d  = 1'b1;
                    abort_d      = 1'b1;
                    state_d      = RESP;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            WAIT_DONE: begin
                if (fpu_ready) begin
                    rsp_data_d   = fpu_data_out;
                    rsp_status_d = fpu_status;
                    rsp_cycles_d = cnt_q + 16'd1;
                    rsp_code_d   = 2'd0;
                    rsp_valid_d  = 1'b1;
                    state_d      = RESP;
                end else if (cnt_q == 16'(TIMEOUT_CYCLES - 1)) begin
                    // A hung core is aborted rather than stalling the host
                    rsp_data_d   = 80'd0;
                    rsp_status_d = fpu_status;
                    rsp_cycles_d = 16'(TIMEOUT_CYCLES);
                    rsp_code_d   = 2'd2;
                    rsp_valid_d  = 1'b1;
                    abort_d      = 1'b1;
                    state_d      = RESP;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = IDLE;
                end else begin
                    state_d = RESP;
                end
            end
            default: state_d = IDLE;
        endcase
        wr_ptr_d    = push_s ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d    = pop_s ? rd_ptr_q + AW'(1) : rd_ptr_q;
        count_d     = count_q + (AW+1)'(push_s) - (AW+1)'(pop_s);
        busy_d      = (state_d != IDLE) || (count_d != '0);
        cmd_ready_d = (count_d != (AW+1)'(DEPTH));
    end

    // Command storage; contents need no reset because the pointers gate every read
    always_ff @(posedge clk) begin
        if (push_s) begin
            fifo_mem_q[wr_ptr_q] <= in_cmd_s;
        end
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            cnt_q        <= 16'd0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            op_q         <= '0;
            exec_q       <= 1'b0;
            abort_q      <= 1'b0;
            rsp_valid_q  <= 1'b0;
            rsp_data_q   <= 80'd0;
            rsp_status_q <= 16'd0;
            rsp_code_q   <= 2'd0;
            rsp_cycles_q <= 16'd0;
            busy_q       <= 1'b0;
            cmd_ready_q  <= 1'b1;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            op_q         <= op_d;
            exec_q       <= exec_d;
            abort_q      <= abort_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_data_q   <= rsp_data_d;
            rsp_status_q <= rsp_status_d;
            rsp_code_q   <= rsp_code_d;
            rsp_cycles_q <= rsp_cycles_d;
            busy_q       <= busy_d;
            cmd_ready_q  <= cmd_ready_d;
        end
    end

    assign cmd_ready         = cmd_ready_q;
    assign fpu_instruction   = op_q.inst;
    assign fpu_stack_index   = op_q.idx;
    assign fpu_data_in       = op_q.data;
    assign fpu_has_memory_op = op_q.mem;
    assign fpu_operand_size  = op_q.size;
    assign fpu_is_integer    = op_q.is_int;
    assign fpu_is_bcd        = op_q.bcd;
    assign fpu_execute       = exec_q;
    assign fpu_abort         = abort_q;
    assign rsp_valid         = rsp_valid_q;
    assign rsp_data          = rsp_data_q;
    assign rsp_status        = rsp_status_q;
    assign rsp_code          = rsp_code_q;
    assign rsp_cycles        = rsp_cycles_q;
    assign busy              = busy_q;
endmodule

// File: tb/tb_fpu_cmd_sequencer.sv
// Directed bench for fpu_cmd_sequencer with a behavioural FPU_Core responder.
module tb_fpu_cmd_sequencer;
    localparam int M_NORMAL = 0, M_HANG = 1, M_IGNORE = 2;

    logic clk = 1'b0, reset = 1'b1;
    logic cmd_valid = 1'b0, cmd_ready;
    logic [7:0] cmd_inst = 8'd0;
    logic [2:0] cmd_idx = 3'd0;
    logic [79:0] cmd_data = 80'd0;
    logic cmd_mem = 1'b0, cmd_int = 1'b0, cmd_bcd = 1'b0;
    logic [1:0] cmd_size = 2'd0;
    logic [7:0] fpu_instruction;
    logic [2:0] fpu_stack_index;
    logic [79:0] fpu_data_in, fpu_data_out;
    logic fpu_has_memory_op, fpu_is_integer, fpu_is_bcd, fpu_execute, fpu_ready, fpu_abort;
    logic [1:0] fpu_operand_size, rsp_code;
    logic [15:0] fpu_status, rsp_status, rsp_cycles;
    logic rsp_valid, rsp_ready = 1'b0, busy;
    logic [79:0] rsp_data;

    int n_checks = 0, n_errors = 0, exec_cnt = 0, abort_cnt = 0;
    int model_mode = M_NORMAL, model_lat = 1;
    logic [79:0] model_res = 80'd0;
    logic use_fn = 1'b0, hold_busy = 1'b0, rdy_m;
    logic [15:0] low_left;

    fpu_cmd_sequencer #(.DEPTH(4), .START_WINDOW(100), .TIMEOUT_CYCLES(200)) dut (
        .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_inst(cmd_inst), .cmd_idx(cmd_idx), .cmd_data(cmd_data), .cmd_mem(cmd_mem),
        .cmd_size(cmd_size), .cmd_int(cmd_int), .cmd_bcd(cmd_bcd),
        .fpu_instruction(fpu_instruction), .fpu_stack_index(fpu_stack_index),
        .fpu_data_in(fpu_data_in), .fpu_has_memory_op(fpu_has_memory_op),
        .fpu_operand_size(fpu_operand_size), .fpu_is_integer(fpu_is_integer),
        .fpu_is_bcd(fpu_is_bcd), .fpu_execute(fpu_execute), .fpu_ready(fpu_ready),
        .fpu_data_out(fpu_data_out), .fpu_status(fpu_status), .fpu_abort(fpu_abort),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .rsp_status(rsp_status), .rsp_code(rsp_code), .rsp_cycles(rsp_cycles), .busy(busy));

    always #5 clk = ~clk;

    // FPU_Core model: ready falls the cycle after execute and stays low for model_lat cycles
    always @(posedge clk) begin
        if (reset) begin
            rdy_m <= 1'b1; low_left <= 16'd0; fpu_data_out <= 80'd0; fpu_status <= 16'd0;
        end else if (fpu_abort) begin
            rdy_m <= 1'b1;
        end else if (fpu_execute) begin
            fpu_status <= {8'h5A, fpu_instruction};
            if (model_mode != M_IGNORE) begin
                rdy_m <= 1'b0; low_left <= 16'(model_lat - 1);
            end
        end else if (!rdy_m && model_mode == M_NORMAL) begin
            if (low_left == 16'd0) begin
                rdy_m <= 1'b1;
                fpu_data_out <= use_fn ? ~fpu_data_in : model_res;
            end else begin
                low_left <= low_left - 16'd1;
            end
        end
    end
    assign fpu_ready = rdy_m & ~hold_busy;

    always @(negedge clk) begin
        if (fpu_execute) exec_cnt++;
        if (fpu_abort) abort_cnt++;
    end

    task automatic check(input string name, input logic [79:0] act, input logic [79:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Enter and leave at a negedge; the command is accepted at the posedge in between
    task automatic push(input logic [7:0] inst, input logic [79:0] data);
        int t = 0;
        cmd_valid = 1'b1; cmd_inst = inst; cmd_data = data; cmd_idx = inst[2:0];
        while (!cmd_ready && t < 2000) begin @(negedge clk); t++; end
        if (t >= 2000) check("push_timeout", 80'(t), 80'd0);
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic wait_exec(output int ok);
        int t = 0;
        while (!fpu_execute && t < 2000) begin @(negedge clk); t++; end
        ok = (t < 2000) ? 1 : 0;
        if (ok == 0) check("exec_timeout", 80'(t), 80'd0);
    endtask

    task automatic drain(input int n, input logic [7:0] inst0, input logic [79:0] data0);
        int got = 0, t = 0;
        rsp_ready = 1'b1;
        while (got < n && t < 5000) begin
            if (rsp_valid) begin
                check("drain_data", rsp_data, ~(data0 + 80'(got)));
                check("drain_sts", 80'(rsp_status), 80'({8'h5A, inst0 + 8'(got)}));
                check("drain_code", 80'(rsp_code), 80'd0);
                got++;
            end
            @(negedge clk); t++;
        end
        rsp_ready = 1'b0;
        check("drain_count", 80'(got), 80'(n));
    endtask

    typedef struct {
        logic [7:0] inst; logic [79:0] data; int mode; int lat; logic [79:0] res;
        logic [1:0] code; logic [15:0] cycles; logic [79:0] rdata; int delay; int aborts;
    } vec_t;
    vec_t vecs[6];

    task automatic run_vec(input vec_t v, input string tag);
        int e0, a0, ok, d;
        e0 = exec_cnt; a0 = abort_cnt;
        model_mode = v.mode; model_lat = v.lat; model_res = v.res; use_fn = 1'b0;
        push(v.inst, v.data);
        wait_exec(ok);
        if (ok == 1) begin
            check({tag, "_op_inst"}, 80'(fpu_instruction), 80'(v.inst));
            check({tag, "_op_data"}, fpu_data_in, v.data);
            check({tag, "_op_idx"}, 80'(fpu_stack_index), 80'(v.inst[2:0]));
            d = 0;
            while (!rsp_valid && d < 30000) begin @(negedge clk); d++; end
            check({tag, "_delay"}, 80'(d), 80'(v.delay));
            check({tag, "_code"}, 80'(rsp_code), 80'(v.code));
            check({tag, "_cycles"}, 80'(rsp_cycles), 80'(v.cycles));
            check({tag, "_data"}, rsp_data, v.rdata);
            if (v.code != 2'd1) check({tag, "_sts"}, 80'(rsp_status), 80'({8'h5A, v.inst}));
            rsp_ready = 1'b1; @(negedge clk); rsp_ready = 1'b0;
            check({tag, "_valid_drop"}, 80'(rsp_valid), 80'd0);
            repeat (3) @(negedge clk);
            check({tag, "_execs"}, 80'(exec_cnt - e0), 80'd1);
            check({tag, "_aborts"}, 80'(abort_cnt - a0), 80'(v.aborts));
        end
    endtask

    initial begin : main
        int ok, e0, a0;
        logic [79:0] s_data; logic [15:0] s_cyc;
        vecs[0] = '{8'hC9, 80'h4000_8000000000000000, M_NORMAL, 5, 80'h4000_8000000000000000,
                    2'd0, 16'd5, 80'h4000_8000000000000000, 7, 0};
        vecs[1] = '{8'hC1, 80'h3FFF_8000000000000000, M_NORMAL, 1, 80'h4000_C000000000000000,
                    2'd0, 16'd1, 80'h4000_C000000000000000, 3, 0};
        vecs[2] = '{8'hF9, 80'h1234_5678_9ABC_DEF0_1122, M_NORMAL, 17, 80'hBEEF_0000_1111_2222_3333,
                    2'd0, 16'd17, 80'hBEEF_0000_1111_2222_3333, 19, 0};
        vecs[3] = '{8'hCA, 80'h7FFE_FFFFFFFFFFFFFFFF, M_HANG, 1, 80'hDEAD,
                    2'd2, 16'd200, 80'd0, 202, 1};
        vecs[4] = '{8'hCB, 80'h0001_8000000000000000, M_IGNORE, 1, 80'hDEAD,
                    2'd1, 16'd0, 80'd0, 101, 1};
        vecs[5] = '{8'hC2, 80'h4001_A000000000000000, M_NORMAL, 2, 80'h5555_AAAA_5555_AAAA_5555,
                    2'd0, 16'd2, 80'h5555_AAAA_5555_AAAA_5555, 4, 0};

        repeat (3) @(negedge clk);
        reset = 1'b0;
        check("rst_cmd_ready", 80'(cmd_ready), 80'd1);
        check("rst_busy", 80'(busy), 80'd0);
        check("rst_rsp_valid", 80'(rsp_valid), 80'd0);
        check("rst_exec_abort", 80'({fpu_execute, fpu_abort}), 80'd0);
        check("rst_rsp_data", rsp_data, 80'd0);
        check("rst_fpu_inst", 80'(fpu_instruction), 80'd0);

        for (int i = 0; i < 6; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

        // Back-pressure: five commands with responses stalled
        model_mode = M_NORMAL; model_lat = 2; use_fn = 1'b1;
        for (int i = 0; i < 5; i++) push(8'h10 + 8'(i), 80'h100 + 80'(i));
        check("bp_cmd_ready_full", 80'(cmd_ready), 80'd0);
        e0 = 0;
        while (!rsp_valid && e0 < 100) begin @(negedge clk); e0++; end
        s_data = rsp_data; s_cyc = rsp_cycles;
        repeat (8) @(negedge clk);
        check("bp_stall_valid", 80'(rsp_valid), 80'd1);
        check("bp_stall_data", rsp_data, s_data);
        check("bp_stall_cycles", 80'(rsp_cycles), 80'(s_cyc));
        check("bp_busy", 80'(busy), 80'd1);
        drain(5, 8'h10, 80'h100);
        repeat (4) @(negedge clk);
        check("bp_idle_busy", 80'(busy), 80'd0);

        // Push and pop in the same cycle with three entries queued
        hold_busy = 1'b1;
        for (int i = 0; i < 3; i++) push(8'h20 + 8'(i), 80'h200 + 80'(i));
        check("pp_ready_3", 80'(cmd_ready), 80'd1);
        hold_busy = 1'b0;
        push(8'h23, 80'h203);
        check("pp_ready_after", 80'(cmd_ready), 80'd1);
        push(8'h24, 80'h204);
        check("pp_ready_full", 80'(cmd_ready), 80'd0);
        drain(5, 8'h20, 80'h200);
        repeat (4) @(negedge clk);

        // Reset while waiting for a hung operation, with one command still queued
        e0 = exec_cnt; a0 = abort_cnt;
        model_mode = M_HANG; use_fn = 1'b0;
        push(8'h30, 80'h300);
        wait_exec(ok);
        push(8'h31, 80'h301);
        repeat (51) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("mid_rst_busy", 80'(busy), 80'd0);
        check("mid_rst_rsp_valid", 80'(rsp_valid), 80'd0);
        check("mid_rst_cmd_ready", 80'(cmd_ready), 80'd1);
        check("mid_rst_abort", 80'(fpu_abort), 80'd0);
        reset = 1'b0;
        repeat (6) @(negedge clk);
        check("mid_rst_execs", 80'(exec_cnt - e0), 80'd1);
        check("mid_rst_aborts", 80'(abort_cnt - a0), 80'd0);
        run_vec(vecs[0], "post_rst");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
